// File: rtl/mdu_pkg.sv
// mdu_pkg: MDUOp encodings, FSM states and default latencies shared by the multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mfhi  = 4'd5,
        MDU_mflo  = 4'd6,
        MDU_mthi  = 4'd7,
        MDU_mtlo  = 4'd8,
        MDU_madd  = 4'd9,
        MDU_maddu = 4'd10,
        MDU_msub  = 4'd11,
        MDU_msubu = 4'd12
    } mdu_op_e;

    typedef enum logic {IDLE, RUN} state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage request/response bundle between the pipeline and the multiply/divide unit
interface mdu_if;

    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;

    modport master (output start, MDUOp, A, B, input busy, HI, LO, MDUout);
    modport slave  (input start, MDUOp, A, B, output busy, HI, LO, MDUout);

endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO; madd/maddu/msub/msubu enabled by MDU_MADD_EN
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);

    state_e      state;
    logic [3:0]  cnt;
    logic        busy;
    logic [31:0] hi, lo, tmp_hi, tmp_lo;
    logic [3:0]  op;
    logic        is_mul, is_div, sgn;
    logic [63:0] prod, mul_res, div_res, res;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;

    assign op     = bus.MDUOp;
    assign is_div = op == MDU_div || op == MDU_divu;

`ifdef MDU_MADD_EN
    logic is_acc, is_sub;
    assign is_acc  = op == MDU_madd || op == MDU_maddu || op == MDU_msub || op == MDU_msubu;
    assign is_sub  = op == MDU_msub || op == MDU_msubu;
    assign is_mul  = op == MDU_mult || op == MDU_multu || is_acc;
    assign sgn     = op == MDU_mult || op == MDU_div || op == MDU_madd || op == MDU_msub;
    // accumulate base is the architectural HI/LO seen at the start edge
    assign mul_res = !is_acc ? prod : is_sub ? {hi, lo} - prod : {hi, lo} + prod;
`else
    assign is_mul  = op == MDU_mult || op == MDU_multu;
    assign sgn     = op == MDU_mult || op == MDU_div;
    assign mul_res = prod;
`endif

    // low 64 bits of the sign- or zero-extended product are exact for both flavours
    assign prod = {{32{sgn & bus.A[31]}}, bus.A} * {{32{sgn & bus.B[31]}}, bus.B};

    // divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend
    assign a_mag   = (sgn & bus.A[31]) ? -bus.A : bus.A;
    assign b_mag   = (sgn & bus.B[31]) ? -bus.B : bus.B;
    assign q_mag   = a_mag / b_mag;
    assign r_mag   = a_mag % b_mag;
    assign q       = (sgn & (bus.A[31] ^ bus.B[31])) ? -q_mag : q_mag;
    assign r       = (sgn & bus.A[31]) ? -r_mag : r_mag;
    // divide by zero reloads the current HI/LO so completion leaves them unchanged
    assign div_res = (bus.B == 32'd0) ? {hi, lo} : {r, q};
    assign res     = is_div ? div_res : mul_res;

    assign bus.busy   = busy;
    assign bus.HI     = hi;
    assign bus.LO     = lo;
    assign bus.MDUout = op == MDU_mfhi ? hi : op == MDU_mflo ? lo : 32'd0;

    // launch/count/commit FSM; results stay in tmp_* until the final busy cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
        end else if (state == IDLE) begin
            if (bus.start && (is_mul || is_div)) begin
                {tmp_hi, tmp_lo} <= res;
                cnt   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
            end else if (bus.start && op == MDU_mthi) begin
                hi <= bus.A;
            end else if (bus.start && op == MDU_mtlo) begin
                lo <= bus.A;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi    <= tmp_hi;
                lo    <= tmp_lo;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    // the hazard unit must never issue while busy; such a request is dropped
    assert property (@(posedge clk) disable iff (reset) !(bus.start && busy))
        else $warning("mdu: start while busy ignored");

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven self-checking bench for mdu plus reset/overlap/madd sequences
module tb_mdu;
    import mdu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int compared = 0;
    int mismatched = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    vec_t vt[12];

    always #5 clk = ~clk;

    mdu_if bus();
    mdu dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // issue one op from a negedge; inj>0 presents an mthi during that busy cycle
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int en, input int inj);
        int n = 0;
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_none;
        while (bus.busy && n < 40) begin
            n++;
            chk("hold_hi", bus.HI, m_hi);
            chk("hold_lo", bus.LO, m_lo);
            bus.start = (n == inj);
            bus.MDUOp = (n == inj) ? MDU_mthi : MDU_none;
            bus.A = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.MDUOp = MDU_none;
        chk("busy_cycles", 32'(n), 32'(en));
        chk("hi", bus.HI, eh);
        chk("lo", bus.LO, el);
        m_hi = eh;
        m_lo = el;
        bus.MDUOp = MDU_mfhi;
        #1 chk("mfhi", bus.MDUout, eh);
        bus.MDUOp = MDU_mflo;
        #1 chk("mflo", bus.MDUout, el);
        bus.MDUOp = MDU_none;
        #1 chk("mdu_none_out", bus.MDUout, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        vt[0]  = '{MDU_mult,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vt[1]  = '{MDU_multu, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vt[2]  = '{MDU_div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3]  = '{MDU_divu,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[4]  = '{MDU_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vt[5]  = '{MDU_divu,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 10};
        vt[6]  = '{MDU_mult,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vt[7]  = '{MDU_div,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[8]  = '{MDU_mthi,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
        vt[9]  = '{MDU_mtlo,  32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0};
        vt[10] = '{MDU_none,  32'h11111111, 32'd3,        32'h12345678, 32'hCAFEBABE, 0};
        vt[11] = '{4'd13,     32'h22222222, 32'd5,        32'h12345678, 32'hCAFEBABE, 0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.MDUOp = MDU_none;
        bus.A = 32'd0;
        bus.B = 32'd0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_out", bus.MDUout, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].n, 0);

        // asynchronous reset in the 4th busy cycle of a div
        bus.start = 1'b1;
        bus.MDUOp = MDU_div;
        bus.A = 32'd100;
        bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_none;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        chk("pre_rst_hi", bus.HI, 32'h12345678);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_hi", bus.HI, 32'd0);
        chk("async_rst_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            seen = seen | bus.busy;
            n++;
        end
        chk("post_rst_busy", 32'(seen), 32'd0);
        chk("post_rst_hi", bus.HI, 32'd0);
        chk("post_rst_lo", bus.LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // start during busy (mthi injected in busy cycle 2) must be ignored
        run_op(MDU_mult, 32'd3, 32'd3, 32'd0, 32'd9, 5, 2);

`ifdef MDU_MADD_EN
        run_op(MDU_mtlo, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_op(MDU_maddu, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
        run_op(MDU_msub, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1, 5, 0);
`else
        run_op(MDU_mtlo, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_op(MDU_maddu, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 0);
        run_op(MDU_msub, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the ALU in E and receives the same forwarded operands A/B.
- Owns the HI/LO registers and runs the mult/div/mthi/mtlo/mfhi/mflo family.
- MDUout is muxed with ALUout into the E/M pipeline register.
- busy feeds the hazard unit, which stalls D while any MDU-class instruction waits.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  qualifies MDUOp in E for this cycle.
- MDUOp  input  4  operation code; encodings in macro.v.
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- busy  output  1  high while a multi-cycle operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUout  output  32  mfhi→HI, mflo→LO, otherwise 0; combinational from the current registers.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0, result temporaries=0, state=IDLE.
  - Any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, start=1 with a mult-class op:
  - At the edge, the full 64-bit result is computed and latched into tmpHI/tmpLO.
  - counter loads MULT_CYCLES; state goes to RUN.
- IDLE, start=1 with a div-class op: same as mult-class, but counter loads DIV_CYCLES.
- busy=1 in every RUN cycle, so exactly N cycles starting the cycle after start.
  - The hazard unit also treats (start && MDU-class op) as stall, covering the start cycle.
- RUN: counter decrements each edge. At the edge where counter==1:
  - HI<=tmpHI, LO<=tmpLO, state goes to IDLE.
  - busy drops in the following cycle.
- mthi / mtlo with start=1 in IDLE: HI<=A or LO<=A at the next edge; busy stays 0.
- mfhi / mflo: no state change; MDUout is valid in the same cycle.
- start=1 while busy: ignored, no state change. A simulation assertion fires; the hazard unit must prevent this case.
- MDUOp none/unknown with start=1: no-op.
- Arithmetic:
  - mult = $signed 32×32→64. multu = unsigned. {HI,LO} = product.
  - div: LO=quotient, truncated toward zero; HI=remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu is unsigned.
  - Divide by zero (div or divu): busy still runs the full DIV_CYCLES, then HI/LO are left unchanged.
- HI/LO are visible only after completion. mfhi in the cycle after busy falls returns the new value.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds madd, maddu, msub, msubu.
  - Result is {HI,LO} ± (A×B), signed or unsigned, mod 2^64.
  - The accumulate base is HI/LO sampled at the start edge.
  - Uses MULT_CYCLES latency; written at completion like mult.
- Undefined: those four encodings decode as no-op; no extra 64-bit adder is synthesised.

Decomposition:
- macro.v holds the MDUOp encodings:
  - MDU_none=0, MDU_mult=1, MDU_multu=2, MDU_div=3, MDU_divu=4.
  - MDU_mfhi=5, MDU_mflo=6, MDU_mthi=7, MDU_mtlo=8.
  - MDU_madd=9, MDU_maddu=10, MDU_msub=11, MDU_msubu=12.
- macro.v also holds the MULT_CYCLES and DIV_CYCLES defaults, shared with the hazard unit.
- No sub-module. The counter/FSM and the result datapath are small enough for a single module.

Test Plan:
- mult, A=0xFFFFFFFF, B=2:
  - busy high for exactly 5 cycles.
  - Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - HI/LO hold their old values while busy.
- multu, A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div, A=0xFFFFFFF9 (-7), B=2:
  - busy for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A following divu with A=7, B=0 leaves HI/LO unchanged after 10 busy cycles.
- mthi A=0x12345678, then mflo/mfhi:
  - MDUout=0x12345678 on mfhi in the next cycle.
  - busy never asserts.
- Reset mid-operation:
  - Start div, assert reset in busy cycle 4.
  - busy, HI and LO go to 0 immediately; no later write occurs.
  - start=1 presented during busy is ignored.
- Optional feature (MDU_MADD_EN): preload HI=0, LO=0xFFFFFFFF via mtlo, then maddu A=1, B=1 → HI=1, LO=0.
